button_reader: RTL and testbench

- Input-side counterpart to the LED driver: reads a raw mechanical push-button and turns it into clean, single-clock-domain events.
- Synchronizes the asynchronous pin, normalizes polarity and debounces with a stable-time counter.
- Emits a debounced level plus one-cycle press, release and long-press pulses for use by board-level control logic.

---
 rtl/button_reader_pkg.sv | 19 +
 rtl/button_sync.sv | 36 +++
 rtl/button_reader.sv | 147 ++++++++++++++
 tb/tb_button_reader.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_reader_pkg.sv
// rtl/button_reader_pkg.sv - shared state type and time conversion for the push-button reader
//
// Purpose: FSM state encoding and the millisecond-to-clock-cycle helper
// used to size the debounce and long-press counters.
// Ports: none (package).

package button_reader_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } state_t;

    function automatic int ms_to_cycles(input int clk_freq, input int ms);
        return (clk_freq / 1000) * ms;
    endfunction

endpackage

// File: rtl/button_sync.sv
// rtl/button_sync.sv - two-flop synchronizer with polarity normalization
//
// Purpose: brings the asynchronous button pin into the clk domain and
// presents it as s, where 1 always means "pressed".
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   btn_raw  in   asynchronous button pin
//   s        out  synchronized, normalized level (1 = pressed)

module button_sync #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic s
);

    logic sync_a;
    logic sync_b;

    // Both flops reset to the raw pin level that means "not pressed".
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= ACTIVE_LOW;
            sync_b <= ACTIVE_LOW;
        end else begin
            sync_a <= btn_raw;
            sync_b <= sync_a;
        end
    end

    assign s = sync_b ^ ACTIVE_LOW;

endmodule

// File: rtl/button_reader.sv
// rtl/button_reader.sv - debounced push-button reader with press/release/long-press pulses
//
// Purpose: synchronizes and debounces a mechanical button, then emits a
// clean level plus one-cycle press, release and long-press events.
// Ports:
//   clk            in   system clock
//   rst            in   synchronous active-high reset
//   btn_raw        in   asynchronous button pin
//   pressed        out  debounced level, 1 = held
//   press_pulse    out  one cycle on debounced press
//   release_pulse  out  one cycle on debounced release
//   long_pulse     out  one cycle once a press has been held L cycles

module button_reader
    import button_reader_pkg::*;
#(
    parameter int CLK_FREQ    = 100_000_000,
    parameter int DEBOUNCE_MS = 10,
    parameter int LONG_MS     = 1000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int D  = ms_to_cycles(CLK_FREQ, DEBOUNCE_MS);
    localparam int L  = ms_to_cycles(CLK_FREQ, LONG_MS);
    localparam int CW = (D < 1) ? 1 : $clog2(D + 1);
    localparam int HW = (L < 1) ? 1 : $clog2(L + 1);

    localparam logic [CW-1:0] DB_LAST   = CW'(D - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(L - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(L);

    if (D < 1) begin : g_bad_debounce
        $error("button_reader: debounce time is shorter than one clock cycle");
    end
    if (L < 1) begin : g_bad_long
        $error("button_reader: long-press time is shorter than one clock cycle");
    end

    logic          s;
    logic [CW-1:0] db_cnt;
    logic [HW-1:0] hold_cnt;
    logic          db_done;
    logic          db_rise;
    logic          db_fall;
    state_t        state_q;
    state_t        state_d;
    logic          press_d;
    logic          release_d;
    logic          long_d;

    button_sync #(
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_raw),
        .s       (s)
    );

    // The debounced level flips on the D-th consecutive edge that sees s
    // disagree with it; any agreeing edge in between restarts the count.
    assign db_done = (s != pressed) && (db_cnt == DB_LAST);
    assign db_rise = db_done && s;
    assign db_fall = db_done && !s;

    always_ff @(posedge clk) begin
        if (rst) begin
            pressed <= 1'b0;
            db_cnt  <= '0;
        end else if (s == pressed) begin
            db_cnt  <= '0;
        end else if (db_cnt == DB_LAST) begin
            pressed <= s;
            db_cnt  <= '0;
        end else begin
            db_cnt  <= db_cnt + CW'(1);
        end
    end

    // Release is checked before the long-press condition so that a release
    // landing on the long-press edge wins and no long pulse is produced.
    always_comb begin
        state_d   = state_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (db_rise) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                end
            end
            PRESSED: begin
                if (db_fall) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_d = LONG_HELD;
                    long_d  = 1'b1;
                end
            end
            LONG_HELD: begin
                if (db_fall) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
        end else begin
            state_q       <= state_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
            long_pulse    <= long_d;
        end
    end

    // Hold counter starts from zero on the press edge and saturates so a
    // button held indefinitely can never wrap into a second long pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if (press_d) begin
            hold_cnt <= '0;
        end else if (state_q == PRESSED && hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + HW'(1);
        end
    end

endmodule

// File: tb/tb_button_reader.sv
// tb/tb_button_reader.sv - self-checking bench for button_reader

module tb_button_reader;

    localparam int D = 10;
    localparam int L = 100;
    localparam bit AL = 1'b0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_raw = 1'b0;
    logic pressed;
    logic press_pulse;
    logic release_pulse;
    logic long_pulse;

    int n_assert = 0;
    int n_fail = 0;

    button_reader #(
        .CLK_FREQ    (1000),
        .DEBOUNCE_MS (10),
        .LONG_MS     (100),
        .ACTIVE_LOW  (AL)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_raw       (btn_raw),
        .pressed       (pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse)
    );

    always #5 clk = ~clk;

    // Reference model: full history of pin samples and reset per edge.
    bit raw_h[$];
    bit rst_h[$];
    bit m_pressed = 1'b0;
    bit m_press = 1'b0;
    bit m_rel = 1'b0;
    bit m_long = 1'b0;
    bit m_long_done = 1'b0;
    int press_edge = 0;

    // Level seen by the debouncer at edge n: pin sampled two edges earlier,
    // forced to "not pressed" if either intervening edge was a reset.
    function automatic bit s_at(input int n);
        if (n < 2) return 1'b0;
        if (rst_h[n-1] || rst_h[n-2]) return 1'b0;
        return raw_h[n-2] ^ AL;
    endfunction

    // True when the last D edges (ending at n) were all out of reset and all saw level v.
    function automatic bit window_ok(input int n, input bit v);
        for (int k = 0; k < D; k++) begin
            int idx = n - k;
            if (idx < 0) return 1'b0;
            if (rst_h[idx]) return 1'b0;
            if (s_at(idx) != v) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_edge();
        int n;
        raw_h.push_back(btn_raw);
        rst_h.push_back(rst);
        n = raw_h.size() - 1;
        m_press = 1'b0;
        m_rel = 1'b0;
        m_long = 1'b0;
        if (rst) begin
            m_pressed = 1'b0;
            m_long_done = 1'b0;
        end else if (window_ok(n, !m_pressed)) begin
            m_pressed = !m_pressed;
            if (m_pressed) begin
                m_press = 1'b1;
                press_edge = n;
                m_long_done = 1'b0;
            end else begin
                m_rel = 1'b1;
            end
        end else if (m_pressed && !m_long_done && (n - press_edge) == L) begin
            m_long = 1'b1;
            m_long_done = 1'b1;
        end
    endtask

    function automatic logic [3:0] obs();
        return {pressed, press_pulse, release_pulse, long_pulse};
    endfunction

    function automatic logic [3:0] expv();
        return {m_pressed, m_press, m_rel, m_long};
    endfunction

    // Drive one edge's inputs, update the model at the edge, return at the next negedge.
    task automatic step(input logic raw, input logic r);
        btn_raw = raw;
        rst = r;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic settle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1);
            n_assert++;
            if (obs() !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_hold cycle %0d: got %b want 0000", i, obs());
            end
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0);
            n_assert++;
            if (obs() !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d: got %b want 0000", i, obs());
            end
        end
    endtask

    task automatic test_clean_press();
        int press_idx = -1;
        int press_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            step(1'b1, 1'b0);
            n_assert++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL clean_press cycle %0d: got %b want %b", i, obs(), expv());
            end
            if (i == 10) begin
                n_assert++;
                if (pressed !== 1'b0) begin
                    n_fail++;
                    $display("FAIL clean_press_early: pressed=%b after E10, want 0", pressed);
                end
            end
            if (press_pulse) begin
                press_cnt++;
                press_idx = i;
            end
        end
        n_assert++;
        if (press_idx !== 11 || press_cnt !== 1) begin
            n_fail++;
            $display("FAIL clean_press_timing: pulse at %0d count %0d, want at 11 count 1", press_idx, press_cnt);
        end
        settle(20);
    endtask

    task automatic test_bounce();
        int press_idx = -1;
        int press_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            step((i >= 24) || ((i % 6) != 5), 1'b0);
            n_assert++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL bounce cycle %0d: got %b want %b", i, obs(), expv());
            end
            if (press_pulse) begin
                press_cnt++;
                press_idx = i;
            end
        end
        n_assert++;
        if (press_idx !== 35 || press_cnt !== 1) begin
            n_fail++;
            $display("FAIL bounce_timing: pulse at %0d count %0d, want at 35 count 1", press_idx, press_cnt);
        end
        settle(20);
    endtask

    // Hold for 'hold' cycles then release; checks every cycle and event positions.
    task automatic test_hold(input int hold, input int want_long, input int want_rel);
        int press_idx = -1;
        int long_idx = -1;
        int rel_idx = -1;
        int long_cnt = 0;
        int rel_cnt = 0;
        for (int i = 0; i < hold + 30; i++) begin
            step(i < hold, 1'b0);
            n_assert++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL hold%0d cycle %0d: got %b want %b", hold, i, obs(), expv());
            end
            if (press_pulse) press_idx = i;
            if (long_pulse) begin
                long_cnt++;
                long_idx = i;
            end
            if (release_pulse) begin
                rel_cnt++;
                rel_idx = i;
            end
        end
        n_assert++;
        if (press_idx !== 11) begin
            n_fail++;
            $display("FAIL hold%0d_press: pulse at %0d, want 11", hold, press_idx);
        end
        n_assert++;
        if (long_idx !== want_long || long_cnt !== (want_long >= 0 ? 1 : 0)) begin
            n_fail++;
            $display("FAIL hold%0d_long: at %0d count %0d, want at %0d", hold, long_idx, long_cnt, want_long);
        end
        n_assert++;
        if (rel_idx !== want_rel || rel_cnt !== 1) begin
            n_fail++;
            $display("FAIL hold%0d_release: at %0d count %0d, want at %0d count 1", hold, rel_idx, rel_cnt, want_rel);
        end
    endtask

    task automatic test_reset_mid_press();
        int press_idx = -1;
        int rel_cnt = 0;
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
        n_assert++;
        if (pressed !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_pre: pressed=%b, want 1", pressed);
        end
        step(1'b1, 1'b1);
        n_assert++;
        if (obs() !== 4'b0000) begin
            n_fail++;
            $display("FAIL midreset_edge: got %b want 0000", obs());
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0);
            n_assert++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL midreset cycle %0d: got %b want %b", i, obs(), expv());
            end
            if (press_pulse) press_idx = i;
            if (release_pulse) rel_cnt++;
        end
        n_assert++;
        if (press_idx !== 11 || rel_cnt !== 0) begin
            n_fail++;
            $display("FAIL midreset_repress: press at %0d releases %0d, want press at 11 releases 0", press_idx, rel_cnt);
        end
        settle(20);
    endtask

    task automatic test_random();
        logic cur = 1'b0;
        int run_left = 0;
        for (int i = 0; i < 2500; i++) begin
            logic rr;
            if (run_left == 0) begin
                int r;
                cur = !cur;
                r = $urandom_range(0, 9);
                if (r < 3) run_left = $urandom_range(1, 3);
                else if (r < 7) run_left = $urandom_range(5, 30);
                else run_left = $urandom_range(90, 160);
            end
            rr = ($urandom_range(0, 299) == 0);
            step(cur, rr);
            run_left--;
            n_assert++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL random cycle %0d: got %b want %b", i, obs(), expv());
            end
            n_assert++;
            if ($countones({press_pulse, release_pulse, long_pulse}) > 1) begin
                n_fail++;
                $display("FAIL random_exclusive cycle %0d: pulses %b, want at most one",
                         i, {press_pulse, release_pulse, long_pulse});
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_hold(200, 111, 211);
        test_hold(50, -1, 61);
        test_hold(100, -1, 111);
        test_reset_mid_press();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
